// File: rtl/irq_pending_capture_pkg.sv
// Shared source-count, index-width and vector types for the interrupt
// pending-capture stage and the downstream priority encoder.
package irq_pkg;

   localparam int N_SRC = 4;
   localparam int IDX_W = $clog2(N_SRC);

   typedef logic [N_SRC-1:0] irq_vec_t;
   typedef logic [IDX_W-1:0] irq_idx_t;

   // An index that names no source decodes to all zeros.
   function automatic irq_vec_t idx_decode(input irq_idx_t idx);
      irq_vec_t dec;
      dec = '0;
      for (int i = 0; i < N_SRC; i++) begin
         dec[i] = (idx == irq_idx_t'(i));
      end
      return dec;
   endfunction

endpackage

// File: rtl/irq_pending_capture_if.sv
// Request/ack/status bundle between the pending-capture stage and its user.
// master drives the request lines, mask and acks; slave is the capture stage.
interface irq_pending_capture_if;
   import irq_pkg::*;

   irq_vec_t irq_in;
   irq_vec_t mask;
   logic     ack_valid;
   irq_idx_t ack_idx;
   logic     clear_ovf;
   irq_vec_t req_vec;
   logic     any_req;
   irq_vec_t ovf;
   logic     spurious_ack;

   modport master (
      output irq_in, mask, ack_valid, ack_idx, clear_ovf,
      input  req_vec, any_req, ovf, spurious_ack
   );

   modport slave (
      input  irq_in, mask, ack_valid, ack_idx, clear_ovf,
      output req_vec, any_req, ovf, spurious_ack
   );

endinterface

// File: rtl/irq_pending_capture_sync_edge.sv
// Rising-edge detector on the request vector. Build option IRQ_SYNC_EN adds a
// 2-flop synchronizer in front of the detector for sources asynchronous to clk.
module irq_sync_edge
   import irq_pkg::*;
(
   input  logic     clk,
   input  logic     rst_n,
   input  irq_vec_t irq_in,
   output irq_vec_t edge_det
);

   irq_vec_t irq_s;
   irq_vec_t irq_d;

`ifdef IRQ_SYNC_EN
   irq_vec_t sync_q1;
   irq_vec_t sync_q2;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q1 <= '0;
         sync_q2 <= '0;
      end else begin
         sync_q1 <= irq_in;
         sync_q2 <= sync_q1;
      end
   end

   assign irq_s = sync_q2;
`else
   assign irq_s = irq_in;
`endif

   // irq_d clears on reset, so a line already high at release is seen as an edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         irq_d <= '0;
      end else begin
         irq_d <= irq_s;
      end
   end

   assign edge_det = irq_s & ~irq_d;

endmodule

// File: rtl/irq_pending_capture.sv
// Sticky pending capture with masking, ack-clear, overflow and spurious-ack flags.
// Optional input synchronizer is selected by defining IRQ_SYNC_EN.
module irq_pending_capture
   import irq_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst_n,
   irq_pending_capture_if.slave bus
);

   irq_vec_t edge_det;
   irq_vec_t pending;
   irq_vec_t pending_nxt;
   irq_vec_t ack_dec;
   irq_vec_t ack_clr;
   irq_vec_t ovf_set;
   logic     ack_hit;

   irq_sync_edge u_sync_edge (
      .clk      (clk),
      .rst_n    (rst_n),
      .irq_in   (bus.irq_in),
      .edge_det (edge_det)
   );

   // A new edge on a bit being acked re-arms it: set wins, and it is not an overflow.
   always_comb begin
      ack_dec     = idx_decode(bus.ack_idx);
      ack_clr     = bus.ack_valid ? ack_dec : '0;
      pending_nxt = edge_det | (pending & ~ack_clr);
      ovf_set     = edge_det & pending & ~ack_clr;
      ack_hit     = |(pending & ack_dec);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending          <= '0;
         bus.req_vec      <= '0;
         bus.any_req      <= 1'b0;
         bus.ovf          <= '0;
         bus.spurious_ack <= 1'b0;
      end else begin
         pending          <= pending_nxt;
         bus.req_vec      <= pending_nxt & bus.mask;
         bus.any_req      <= |(pending_nxt & bus.mask);
         bus.ovf          <= (bus.clear_ovf ? '0 : bus.ovf) | ovf_set;
         bus.spurious_ack <= bus.ack_valid & ~ack_hit;
      end
   end

endmodule

// File: tb/tb_irq_pending_capture.sv
// Self-checking bench for irq_pending_capture: per-cycle model comparison plus
// directed literal checks. Honours IRQ_SYNC_EN for the input latency.
module tb_irq_pending_capture;
   import irq_pkg::*;

`ifdef IRQ_SYNC_EN
   localparam int D = 2;
`else
   localparam int D = 0;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   int   checks = 0;
   int   errors = 0;
   bit   check_en = 1'b0;

   irq_pending_capture_if bus_if ();

   irq_pending_capture dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_if.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: a delay line for the input path, then per-source rules.
   logic [N_SRC-1:0] m_line[$];
   bit               m_prev[N_SRC];
   bit               m_pend[N_SRC];
   bit               m_ovf[N_SRC];
   logic [N_SRC-1:0] m_req = '0;
   logic [N_SRC-1:0] m_ovf_vec = '0;
   bit               m_any = 1'b0;
   bit               m_spur = 1'b0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_line.delete();
         repeat (D) m_line.push_back('0);
         for (int i = 0; i < N_SRC; i++) begin
            m_prev[i] = 1'b0;
            m_pend[i] = 1'b0;
            m_ovf[i]  = 1'b0;
         end
         m_req = '0; m_ovf_vec = '0; m_any = 1'b0; m_spur = 1'b0;
      end else begin
         logic [N_SRC-1:0] samp;
         int               idx;
         bit               rise, acked;
         m_line.push_back(bus_if.irq_in);
         samp = m_line.pop_front();
         idx  = int'(bus_if.ack_idx);
         m_spur = bus_if.ack_valid && (idx >= N_SRC || !m_pend[idx]);
         for (int i = 0; i < N_SRC; i++) begin
            rise  = samp[i] && !m_prev[i];
            acked = bus_if.ack_valid && (idx == i);
            m_ovf[i]  = (m_ovf[i] && !bus_if.clear_ovf) || (rise && m_pend[i] && !acked);
            m_pend[i] = rise || (m_pend[i] && !acked);
            m_prev[i] = samp[i];
            m_req[i]     = m_pend[i] && bus_if.mask[i];
            m_ovf_vec[i] = m_ovf[i];
         end
         m_any = (m_req != '0);
      end
   end

   always @(posedge clk) begin
      #3;
      if (check_en) begin
         chk("cyc_req_vec", bus_if.req_vec, m_req);
         chk("cyc_any_req", bus_if.any_req, m_any);
         chk("cyc_ovf", bus_if.ovf, m_ovf_vec);
         chk("cyc_spurious", bus_if.spurious_ack, m_spur);
      end
   end

   task automatic step();
      @(negedge clk);
   endtask

   // Rise on the given lines, drop them, then let the edge reach the outputs.
   task automatic pulse(input logic [N_SRC-1:0] bits);
      bus_if.irq_in = bits;
      step();
      bus_if.irq_in = '0;
      step();
      repeat (D) step();
   endtask

   task automatic ack(input int idx);
      bus_if.ack_valid = 1'b1;
      bus_if.ack_idx   = irq_idx_t'(idx);
      step();
      bus_if.ack_valid = 1'b0;
   endtask

   initial begin
      bus_if.irq_in    = '0;
      bus_if.mask      = 4'b1111;
      bus_if.ack_valid = 1'b0;
      bus_if.ack_idx   = '0;
      bus_if.clear_ovf = 1'b0;
      #1 rst_n = 1'b0;
      repeat (2) step();
      check_en = 1'b1;
      chk("rst_req_vec", bus_if.req_vec, 4'b0000);
      chk("rst_any_req", bus_if.any_req, 1'b0);
      chk("rst_ovf", bus_if.ovf, 4'b0000);
      chk("rst_spurious", bus_if.spurious_ack, 1'b0);
      rst_n = 1'b1;
      step();

      // 1: single request becomes sticky
      pulse(4'b0100);
      chk("t1_req_vec", bus_if.req_vec, 4'b0100);
      chk("t1_any_req", bus_if.any_req, 1'b1);
      repeat (2) step();
      chk("t1_sticky", bus_if.req_vec, 4'b0100);

      // 2: ack clears, repeated ack is spurious for one cycle
      bus_if.ack_valid = 1'b1;
      bus_if.ack_idx   = 2'd2;
      step();
      chk("t2_req_vec", bus_if.req_vec, 4'b0000);
      chk("t2_any_req", bus_if.any_req, 1'b0);
      chk("t2_no_spur", bus_if.spurious_ack, 1'b0);
      step();
      chk("t2_spur", bus_if.spurious_ack, 1'b1);
      bus_if.ack_valid = 1'b0;
      step();
      chk("t2_spur_drop", bus_if.spurious_ack, 1'b0);

      // 3: second edge while pending -> overflow, then clear_ovf
      pulse(4'b0001);
      chk("t3_req_vec", bus_if.req_vec, 4'b0001);
      chk("t3_no_ovf", bus_if.ovf, 4'b0000);
      pulse(4'b0001);
      chk("t3_ovf", bus_if.ovf, 4'b0001);
      chk("t3_req_same", bus_if.req_vec, 4'b0001);
      bus_if.clear_ovf = 1'b1;
      step();
      bus_if.clear_ovf = 1'b0;
      chk("t3_ovf_clr", bus_if.ovf, 4'b0000);

      // 4: edge and ack on the same pending bit in the same cycle
      pulse(4'b0010);
      chk("t4_req_pre", bus_if.req_vec, 4'b0011);
      bus_if.irq_in = 4'b0010;
      repeat (D) step();
      bus_if.ack_valid = 1'b1;
      bus_if.ack_idx   = 2'd1;
      step();
      bus_if.ack_valid = 1'b0;
      bus_if.irq_in    = '0;
      chk("t4_req_vec", bus_if.req_vec, 4'b0011);
      chk("t4_no_ovf", bus_if.ovf, 4'b0000);
      chk("t4_no_spur", bus_if.spurious_ack, 1'b0);
      step();
      chk("t4_req_hold", bus_if.req_vec, 4'b0011);

      // 5: masked pending bit is retained and exposed on unmask
      ack(0);
      ack(1);
      chk("t5_empty", bus_if.req_vec, 4'b0000);
      bus_if.mask = 4'b1110;
      pulse(4'b0001);
      chk("t5_masked", bus_if.req_vec, 4'b0000);
      chk("t5_masked_any", bus_if.any_req, 1'b0);
      bus_if.mask = 4'b1111;
      step();
      chk("t5_unmask", bus_if.req_vec, 4'b0001);
      chk("t5_unmask_any", bus_if.any_req, 1'b1);

      // 6: async reset mid-cycle, then a line high at release counts as an edge
      ack(0);
      pulse(4'b1010);
      chk("t6_req_pre", bus_if.req_vec, 4'b1010);
      #2 rst_n = 1'b0;
      #1;
      chk("t6_rst_req", bus_if.req_vec, 4'b0000);
      chk("t6_rst_any", bus_if.any_req, 1'b0);
      chk("t6_rst_ovf", bus_if.ovf, 4'b0000);
      chk("t6_rst_spur", bus_if.spurious_ack, 1'b0);
      bus_if.irq_in = 4'b0001;
      step();
      rst_n = 1'b1;
      step();
      repeat (D) step();
      chk("t6_release_edge", bus_if.req_vec, 4'b0001);
      chk("t6_release_any", bus_if.any_req, 1'b1);
      bus_if.irq_in = '0;
      repeat (3) step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
